// File: rtl/func_stream_seq.sv
// Run controller for a streaming kernel: gates the shell/kernel handshakes, admits exactly len
// input vectors per run, counts the outputs, marks the last one and watches for a stalled drain.
module func_stream_seq #(
    parameter int unsigned CNTW    = 32,
    parameter int unsigned TOUT_W  = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic            aclk,
    input  logic            areset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [CNTW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [CNTW-1:0] in_count,
    output logic [CNTW-1:0] out_count,
    input  logic            s_tvalid,
    output logic            s_tready,
    output logic            k_ivalid,
    input  logic            k_iready,
    input  logic            k_ovalid,
    output logic            k_oready,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast
);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone, StErr} state_e;

    localparam logic [TOUT_W-1:0] WdLast = TOUT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   len_q, len_d;
    logic [CNTW-1:0]   in_cnt_q, in_cnt_d;
    logic [CNTW-1:0]   out_cnt_q, out_cnt_d;
    logic [TOUT_W-1:0] wd_q, wd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic run_st, out_room, in_xfer, out_xfer, in_last, out_last, wd_expire;

    assign run_st   = (state_q == StRun);
    // Once the run's outputs are all delivered, surplus kernel outputs stay in the kernel.
    assign out_room = (out_cnt_q != len_q);

    assign s_tready = k_iready & run_st;
    assign k_ivalid = s_tvalid & run_st;
    assign m_tvalid = k_ovalid & busy_q & out_room;
    assign k_oready = m_tready & busy_q & out_room;
    assign m_tlast  = m_tvalid & (out_cnt_q == len_q - CNTW'(1));

    assign in_xfer   = s_tvalid & s_tready;
    assign out_xfer  = m_tvalid & m_tready;
    assign in_last   = in_xfer & ((in_cnt_q + CNTW'(1)) == len_q);
    assign out_last  = out_xfer & ((out_cnt_q + CNTW'(1)) == len_q);
    assign wd_expire = ~out_xfer & (wd_q == WdLast);

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;
    assign in_count  = in_cnt_q;
    assign out_count = out_cnt_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        in_cnt_d  = in_xfer ? in_cnt_q + CNTW'(1) : in_cnt_q;
        out_cnt_d = out_xfer ? out_cnt_q + CNTW'(1) : out_cnt_q;
        wd_d      = wd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        if (abort) begin
            state_d   = StIdle;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            wd_d      = '0;
            busy_d    = 1'b0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        len_d     = len;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        if (len == '0) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRun;
                            busy_d  = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (in_last) begin
                        if (out_last) begin
                            state_d = StDone;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StDrain;
                            wd_d    = '0;
                        end
                    end
                end
                StDrain: begin
                    if (out_last) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (out_xfer) begin
                        wd_d = '0;
                    end else if (wd_expire) begin
                        state_d = StErr;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        wd_d = wd_q + TOUT_W'(1);
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                StErr: begin
                    state_d = StErr;
                end
                default: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= StIdle;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_func_stream_seq.sv
// Randomized bench for func_stream_seq: a latency-configurable kernel stand-in, a run-level
// behavioural model checked every cycle, and directed scenarios pinned by literal expectations.
module tb_func_stream_seq;

    localparam int TO = 20;
    localparam int MIdle = 0, MRun = 1, MDrain = 2, MDone = 3, MErr = 4;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic        start, abort;
    logic [31:0] len;
    logic        busy, done, error;
    logic [31:0] in_count, out_count;
    logic        s_tvalid, s_tready, k_ivalid, k_iready, k_ovalid, k_oready;
    logic        m_tvalid, m_tready, m_tlast;

    func_stream_seq #(.CNTW(32), .TOUT_W(16), .TIMEOUT(TO)) dut (
        .aclk(aclk), .areset_n(areset_n), .start(start), .abort(abort), .len(len),
        .busy(busy), .done(done), .error(error), .in_count(in_count), .out_count(out_count),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .k_ivalid(k_ivalid), .k_iready(k_iready),
        .k_ovalid(k_ovalid), .k_oready(k_oready), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0, n_err = 0, cyc = 0;

    // Kernel stand-in: in-order pipe, each vector emerges lat cycles after acceptance.
    int rdy[64];
    int k_acc = 0, k_del = 0, lat = 1;
    bit k_mute = 0;
    assign k_ovalid = !k_mute &&
        ((k_del != k_acc && rdy[k_del % 64] <= cyc) ||
         (lat == 0 && k_del == k_acc && k_ivalid && k_iready));

    // Run-level model.
    int          mm = MIdle;
    logic [31:0] m_len = 0, m_in = 0, m_out = 0;
    int          m_wd = 0;

    int p_sv = 100, p_kr = 100, p_mr = 100;
    bit tog = 0, noise = 0;

    int n_in, n_out, n_tlast, n_drain, n_done, n_busy, tlast_pos, last_out_cyc, done_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        n_in = 0; n_out = 0; n_tlast = 0; n_drain = 0; n_done = 0; n_busy = 0;
        tlast_pos = -1; last_out_cyc = -1; done_cyc = -1;
    endtask

    task automatic model_reset();
        mm = MIdle; m_len = 0; m_in = 0; m_out = 0; m_wd = 0;
    endtask

    task automatic step();
        logic e_run, e_busy, e_room, e_st, e_kiv, e_mtv, e_kor, e_last;
        logic ix, ox, hs_in, hs_out, flush;
        @(negedge aclk);
        e_run  = (mm == MRun);
        e_busy = (mm == MRun) || (mm == MDrain);
        e_room = (m_out != m_len);
        e_st   = k_iready & e_run;
        e_kiv  = s_tvalid & e_run;
        e_mtv  = k_ovalid & e_busy & e_room;
        e_kor  = m_tready & e_busy & e_room;
        e_last = e_mtv & (m_out == m_len - 32'd1);
        chk("busy", busy, e_busy);
        chk("done", done, mm == MDone);
        chk("error", error, mm == MErr);
        chk("in_count", in_count, m_in);
        chk("out_count", out_count, m_out);
        chk("s_tready", s_tready, e_st);
        chk("k_ivalid", k_ivalid, e_kiv);
        chk("m_tvalid", m_tvalid, e_mtv);
        chk("k_oready", k_oready, e_kor);
        chk("m_tlast", m_tlast, e_last);

        if (s_tvalid && s_tready) n_in++;
        if (m_tvalid && m_tready) begin
            if (m_tlast) begin n_tlast++; tlast_pos = n_out; end
            n_out++;
            last_out_cyc = cyc;
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (busy) n_busy++;
        if (busy && k_iready && !s_tready) n_drain++;

        ix = s_tvalid & e_st;
        ox = e_mtv & m_tready;
        hs_in  = k_ivalid & k_iready;
        hs_out = k_ovalid & k_oready;
        flush  = abort | !areset_n;

        if (!areset_n) model_reset();
        else if (abort) begin
            mm = MIdle; m_in = 0; m_out = 0; m_wd = 0;
        end else begin
            case (mm)
                MIdle: if (start) begin
                    m_len = len; m_in = 0; m_out = 0;
                    mm = (len == 0) ? MDone : MRun;
                end
                MRun: begin
                    m_in += 32'(ix); m_out += 32'(ox);
                    if (m_in == m_len) begin
                        if (m_out == m_len) mm = MDone;
                        else begin mm = MDrain; m_wd = 0; end
                    end
                end
                MDrain: begin
                    m_out += 32'(ox);
                    if (m_out == m_len) mm = MDone;
                    else if (ox) m_wd = 0;
                    else begin
                        m_wd++;
                        if (m_wd == TO) mm = MErr;
                    end
                end
                MDone: mm = MIdle;
                default: ;
            endcase
        end

        @(posedge aclk);
        #1;
        if (flush) begin k_acc = 0; k_del = 0; end
        else begin
            if (hs_in) begin rdy[k_acc % 64] = cyc + lat; k_acc++; end
            if (hs_out) k_del++;
        end
        cyc++;
        start = 0; abort = 0;
        s_tvalid = ($urandom_range(99) < p_sv);
        k_iready = ($urandom_range(99) < p_kr);
        if (tog) m_tready = ~m_tready;
        else m_tready = ($urandom_range(99) < p_mr);
        if (noise && (mm == MRun || mm == MDrain) && $urandom_range(99) < 5) begin
            start = 1; len = $urandom_range(50);
        end
    endtask

    task automatic do_run(input logic [31:0] l, input int budget);
        int d0;
        bit ok;
        d0 = n_done;
        ok = 0;
        len = l; start = 1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (n_done != d0) begin ok = 1; break; end
        end
        chk("run_completes", ok, 1);
        step();
    endtask

    initial begin
        areset_n = 0; start = 0; abort = 0; len = 0;
        s_tvalid = 0; k_iready = 0; m_tready = 0;
        clr_stats();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_s_tready", s_tready, 0);
        step(); step();
        areset_n = 1;
        step();

        // len=8, everything ready, latency 5.
        lat = 5; p_sv = 100; p_kr = 100; p_mr = 100; clr_stats();
        do_run(8, 100);
        chk("t1_inputs", n_in, 8);
        chk("t1_outputs", n_out, 8);
        chk("t1_tlast_count", n_tlast, 1);
        chk("t1_tlast_pos", tlast_pos, 7);
        chk("t1_done_gap", done_cyc - last_out_cyc, 1);
        chk("t1_in_count", in_count, 8);
        chk("t1_out_count", out_count, 8);

        // len=0 completes immediately without ever going busy.
        clr_stats();
        len = 0; start = 1;
        step();
        chk("t2_done_next", done, 1);
        step(); step(); step();
        chk("t2_done_once", n_done, 1);
        chk("t2_never_busy", n_busy, 0);

        // len=4 with m_tready toggling.
        lat = 2; tog = 1; m_tready = 0; clr_stats();
        do_run(4, 100);
        tog = 0;
        chk("t3_outputs", n_out, 4);
        chk("t3_tlast", n_tlast, 1);
        chk("t3_no_error", error, 0);

        // Silent kernel: watchdog trips after TO drain cycles.
        k_mute = 1; lat = 1; clr_stats();
        len = 4; start = 1;
        for (int i = 0; i < 100 && !error; i++) step();
        chk("t4_error", error, 1);
        chk("t4_drain_cycles", n_drain, TO);
        len = 3; start = 1;
        step(); step(); step();
        chk("t4_start_ignored_busy", busy, 0);
        chk("t4_error_sticky", error, 1);
        abort = 1;
        step();
        chk("t4_abort_in", in_count, 0);
        chk("t4_abort_out", out_count, 0);
        chk("t4_abort_err", error, 0);
        k_mute = 0;
        step();

        // len=1, zero-latency kernel: RUN straight to DONE.
        lat = 0; clr_stats();
        do_run(1, 20);
        chk("t5_done_once", n_done, 1);
        chk("t5_tlast", n_tlast, 1);
        chk("t5_no_drain", n_drain, 0);
        chk("t5_outputs", n_out, 1);

        // Asynchronous reset mid-run after 3 of 10 inputs.
        lat = 10; clr_stats();
        len = 10; start = 1;
        for (int i = 0; i < 50 && m_in != 3; i++) step();
        chk("t6_three_in", in_count, 3);
        #2 areset_n = 0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in", in_count, 0);
        chk("t6_rst_s_tready", s_tready, 0);
        chk("t6_rst_k_ivalid", k_ivalid, 0);
        chk("t6_rst_m_tvalid", m_tvalid, 0);
        chk("t6_rst_k_oready", k_oready, 0);
        model_reset();
        k_acc = 0; k_del = 0;
        step(); step();
        areset_n = 1;
        lat = 1; clr_stats();
        do_run(2, 50);
        chk("t6_fresh_out", out_count, 2);
        chk("t6_fresh_tlast", n_tlast, 1);

        // Randomized runs with back-pressure, stray starts and occasional aborts.
        noise = 1;
        for (int r = 0; r < 30; r++) begin
            p_sv = $urandom_range(100, 30);
            p_kr = $urandom_range(100, 30);
            p_mr = $urandom_range(100, 30);
            lat  = $urandom_range(4);
            clr_stats();
            if (r % 5 == 4) begin
                len = $urandom_range(12, 1); start = 1;
                step();
                for (int j = 0; j < int'($urandom_range(10, 2)); j++) step();
                abort = 1;
                step();
                chk("rnd_abort_in", in_count, 0);
                chk("rnd_abort_out", out_count, 0);
            end else begin
                do_run($urandom_range(12, 1), 400);
                chk("rnd_tlast", n_tlast, 1);
            end
        end
        noise = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
